// File: rtl/jkc_pkg.sv
// Shared types for the JK counter/register bank: operating modes and JK action encoding.
package jkc_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Action selected by the {j,k} pair of a single flop.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_action_e;

    function automatic jk_action_e jk_action(input logic j, input logic k);
        return jk_action_e'({j, k});
    endfunction

endpackage

// File: rtl/jk_counter_reg_if.sv
// Control/status bundle of jk_counter_reg; the master drives controls, the slave returns state.
interface jk_counter_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, load, din,
        input  q, qbar, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, load, din,
        output q, qbar, tc, wrap
    );
endinterface

// File: rtl/jk_bit.sv
// Single JK flop with async active-low reset, clock enable and synchronous set/clear override.
module jk_bit
    import jkc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic set,
    input  logic clr,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (en) begin
            if (set) begin
                q <= 1'b1;
            end else if (clr) begin
                q <= 1'b0;
            end else begin
                case (jk_action(j, k))
                    JK_SET:    q <= 1'b1;
                    JK_CLEAR:  q <= 1'b0;
                    JK_TOGGLE: q <= ~q;
                    default:   q <= q;
                endcase
            end
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK register bank / up-down modulo counter built from jk_bit flops.
// Define JKC_SATURATE_EN to make the counter modes saturate instead of wrapping.
module jk_counter_reg
    import jkc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic           clk,
    input  logic           rst,
    jk_counter_reg_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    mode_e            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] j_int;
    logic [WIDTH-1:0] k_int;
    logic [WIDTH-1:0] set_int;
    logic [WIDTH-1:0] clr_int;
    logic             lower_ones;
    logic             lower_zeros;
    logic             at_zero;
    logic             at_or_above_max;
    logic             above_max;
    logic             wrap_next;
    logic             wrap_q;

    assign mode            = mode_e'(bus.mode);
    assign at_zero         = (q == '0);
    assign at_or_above_max = (q >= MAX_Q);
    assign above_max       = (q > MAX_Q);

    // Ripple toggle terms: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t        = '0;
        dn_t        = '0;
        lower_ones  = 1'b1;
        lower_zeros = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            up_t[i]     = lower_ones;
            dn_t[i]     = lower_zeros;
            lower_ones  = lower_ones & q[i];
            lower_zeros = lower_zeros & ~q[i];
        end
    end

    // Set/clear override the JK terms inside jk_bit, so a forced value needs both vectors.
    always_comb begin
        j_int     = '0;
        k_int     = '0;
        set_int   = '0;
        clr_int   = '0;
        wrap_next = 1'b0;
        if (bus.load) begin
            set_int = bus.din;
            clr_int = ~bus.din;
        end else begin
            case (mode)
                MODE_JK: begin
                    j_int = bus.j;
                    k_int = bus.k;
                end
                MODE_UP: begin
`ifdef JKC_SATURATE_EN
                    if (at_or_above_max) begin
                        set_int = MAX_Q;
                        clr_int = ~MAX_Q;
                    end else begin
                        j_int = up_t;
                        k_int = up_t;
                    end
`else
                    if (at_or_above_max) begin
                        clr_int   = '1;
                        wrap_next = 1'b1;
                    end else begin
                        j_int = up_t;
                        k_int = up_t;
                    end
`endif
                end
                MODE_DOWN: begin
                    if (above_max) begin
                        set_int = MAX_Q;
                        clr_int = ~MAX_Q;
                    end else if (at_zero) begin
`ifndef JKC_SATURATE_EN
                        set_int   = MAX_Q;
                        clr_int   = ~MAX_Q;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        j_int = dn_t;
                        k_int = dn_t;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_bit (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en),
            .j    (j_int[i]),
            .k    (k_int[i]),
            .set  (set_int[i]),
            .clr  (clr_int[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= bus.en & wrap_next;
        end
    end

    assign bus.q    = q;
    assign bus.qbar = qbar;
    assign bus.tc   = ((mode == MODE_UP) && at_or_above_max) || ((mode == MODE_DOWN) && at_zero);
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Self-checking bench for jk_counter_reg (WIDTH=4, MAX_COUNT=9); honours JKC_SATURATE_EN.
module tb_jk_counter_reg;
    import jkc_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MAXC  = 9;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] mq;
    logic       mwrap;

    always #5 clk = ~clk;

    jk_counter_reg_if #(.WIDTH(WIDTH)) bus ();

    jk_counter_reg #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic exp_tc();
        return ((bus.mode == 2'b01) && (int'(mq) >= int'(MAXC))) ||
               ((bus.mode == 2'b10) && (mq == 4'd0));
    endfunction

    task automatic drive(input logic en_v, input logic load_v, input logic [1:0] mode_v,
                         input logic [3:0] j_v, input logic [3:0] k_v, input logic [3:0] din_v);
        bus.en   = en_v;
        bus.load = load_v;
        bus.mode = mode_v;
        bus.j    = j_v;
        bus.k    = k_v;
        bus.din  = din_v;
    endtask

    // Reference: next state from the arithmetic rules, then advance one clock.
    task automatic step();
        int nq;
        logic nw;
        nq = int'(mq);
        nw = 1'b0;
        if (bus.en && bus.load) begin
            nq = int'(bus.din);
        end else if (bus.en) begin
            case (bus.mode)
                2'b00: for (int b = 0; b < 4; b++) begin
                    if (bus.j[b] && bus.k[b]) nq[b] = ~nq[b];
                    else if (bus.j[b])        nq[b] = 1'b1;
                    else if (bus.k[b])        nq[b] = 1'b0;
                end
                2'b01: begin
`ifdef JKC_SATURATE_EN
                    nq = (nq >= int'(MAXC)) ? int'(MAXC) : nq + 1;
`else
                    if (nq >= int'(MAXC)) begin nq = 0; nw = 1'b1; end
                    else nq = nq + 1;
`endif
                end
                2'b10: begin
                    if (nq > int'(MAXC)) nq = int'(MAXC);
                    else if (nq == 0) begin
`ifndef JKC_SATURATE_EN
                        nq = int'(MAXC);
                        nw = 1'b1;
`endif
                    end else nq = nq - 1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        mq    = nq[3:0];
        mwrap = nw;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'b1011);
        step();
        checks++;
        if (bus.q !== 4'b1011) begin failures++; $display("FAIL reset_preload: q=%b expected %b", bus.q, 4'b1011); end
        #3;
        rst = 1'b0;
        #1;
        mq = 4'd0; mwrap = 1'b0;
        checks++;
        if (bus.q !== 4'b0000) begin failures++; $display("FAIL reset_q: q=%b expected 0000", bus.q); end
        checks++;
        if (bus.qbar !== 4'b1111) begin failures++; $display("FAIL reset_qbar: qbar=%b expected 1111", bus.qbar); end
        checks++;
        if (bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap: wrap=%b expected 0", bus.wrap); end
        checks++;
        if (bus.tc !== 1'b1) begin failures++; $display("FAIL reset_tc_down: tc=%b expected 1", bus.tc); end
        #2;
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
        step();
        checks++;
        if (bus.q !== 4'd1) begin failures++; $display("FAIL reset_first_count: q=%0d expected 1", bus.q); end
    endtask

    task automatic test_jk();
        logic [3:0] js [3] = '{4'b0011, 4'b1111, 4'b0000};
        logic [3:0] ks [3] = '{4'b0000, 4'b1111, 4'b0001};
        logic [3:0] qs [3] = '{4'b0011, 4'b1100, 4'b1100};
        drive(1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'b00, js[i], ks[i], 4'h0);
            step();
            checks++;
            if (bus.q !== qs[i]) begin failures++; $display("FAIL jk_seq%0d: q=%b expected %b", i, bus.q, qs[i]); end
            checks++;
            if (bus.wrap !== 1'b0 || bus.tc !== 1'b0) begin
                failures++; $display("FAIL jk_flags%0d: wrap=%b tc=%b expected 0 0", i, bus.wrap, bus.tc);
            end
        end
    endtask

    task automatic test_up();
        drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #0;
            checks++;
            if (bus.tc !== exp_tc()) begin failures++; $display("FAIL up_tc%0d: tc=%b expected %b (q=%0d)", i, bus.tc, exp_tc(), mq); end
            step();
            checks++;
            if (bus.q !== mq || bus.wrap !== mwrap) begin
                failures++; $display("FAIL up_cnt%0d: q=%0d wrap=%b expected q=%0d wrap=%b", i, bus.q, bus.wrap, mq, mwrap);
            end
        end
    endtask

    task automatic test_down();
        drive(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'd2);
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.q !== mq || bus.wrap !== mwrap || bus.tc !== exp_tc()) begin
                failures++;
                $display("FAIL down_cnt%0d: q=%0d wrap=%b tc=%b expected q=%0d wrap=%b tc=%b",
                         i, bus.q, bus.wrap, bus.tc, mq, mwrap, exp_tc());
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] held;
        held = bus.q;
        drive(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'd5);
        step();
        checks++;
        if (bus.q !== held || bus.wrap !== 1'b0) begin failures++; $display("FAIL en_hold: q=%0d wrap=%b expected q=%0d wrap=0", bus.q, bus.wrap, held); end
        drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'd7);
        step();
        checks++;
        if (bus.q !== 4'd7) begin failures++; $display("FAIL load_over_up: q=%0d expected 7", bus.q); end
        drive(1'b1, 1'b0, 2'b11, 4'hF, 4'h0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.q !== 4'd7 || bus.wrap !== 1'b0 || bus.tc !== 1'b0) begin
                failures++; $display("FAIL hold%0d: q=%0d wrap=%b tc=%b expected q=7 wrap=0 tc=0", i, bus.q, bus.wrap, bus.tc);
            end
        end
    endtask

`ifdef JKC_SATURATE_EN
    task automatic test_saturate();
        drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'd8);
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.q !== 4'd9 || bus.wrap !== 1'b0) begin failures++; $display("FAIL sat_up%0d: q=%0d wrap=%b expected q=9 wrap=0", i, bus.q, bus.wrap); end
        end
        drive(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'd1);
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.q !== 4'd0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL sat_down%0d: q=%0d wrap=%b expected q=0 wrap=0", i, bus.q, bus.wrap); end
        end
        drive(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'd14);
        step();
        bus.load = 1'b0;
        step();
        checks++;
        if (bus.q !== 4'd9) begin failures++; $display("FAIL sat_clamp: q=%0d expected 9", bus.q); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                  4'($urandom), 4'($urandom), 4'($urandom));
            #0;
            checks++;
            if (bus.tc !== exp_tc()) begin failures++; $display("FAIL rnd_tc%0d: tc=%b expected %b (q=%0d mode=%0d)", i, bus.tc, exp_tc(), mq, bus.mode); end
            step();
            checks++;
            if (bus.q !== mq || bus.qbar !== ~mq || bus.wrap !== mwrap) begin
                failures++;
                $display("FAIL rnd_state%0d: q=%0d qbar=%b wrap=%b expected q=%0d qbar=%b wrap=%b",
                         i, bus.q, bus.qbar, bus.wrap, mq, ~mq, mwrap);
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        mq    = 4'd0;
        mwrap = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        #12;
        rst = 1'b1;
        test_reset();
        test_jk();
        test_up();
        test_down();
        test_priority();
`ifdef JKC_SATURATE_EN
        test_saturate();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_counter_reg.md
Name: jk_counter_reg

Overview:
- Parametrised WIDTH-bit register bank of JK flip-flops with a selectable operating mode.
- Modes: per-bit JK register, or synchronous up/down modulo counter. In counter mode the per-bit J/K inputs are driven internally as toggle terms.
- Successor to the single-bit JK flop. Used as a general state/count element in sequential-logic blocks.

Parameters:
- WIDTH, 4, number of JK bits.
- MAX_COUNT, 2**WIDTH-1, terminal value in counter modes. Legal range is 1..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  clock enable; when 0 all state holds.
- mode  input  2  operating mode: 00 JK, 01 UP, 10 DOWN, 11 HOLD.
- j  input  WIDTH  per-bit J (JK mode only).
- k  input  WIDTH  per-bit K (JK mode only).
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  register state.
- qbar  output  WIDTH  always ~q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse, set when the counter wrapped.

Behaviour:
- Reset:
  - rst=0 immediately forces q=0, qbar=all ones, wrap=0, independent of clk.
  - tc follows q and mode, so after reset tc=1 only in DOWN mode.
- Sequencing:
  - All updates occur on the rising edge of clk while rst=1.
  - Latency is 1 cycle from inputs to q.
- Priority, highest first:
  - en=0: hold, wrap<=0.
  - load=1: q<=din, wrap<=0, regardless of mode.
  - Otherwise the mode decides.
- JK mode, per bit i:
  - j=0,k=0: hold.
  - j=1,k=0: set.
  - j=0,k=1: clear.
  - j=1,k=1: toggle.
  - wrap<=0.
- UP mode:
  - q==MAX_COUNT: q<=0, wrap<=1.
  - q>MAX_COUNT (reachable via JK mode or load): q<=0, wrap<=1.
  - Otherwise q<=q+1, wrap<=0.
- DOWN mode:
  - q==0: q<=MAX_COUNT, wrap<=1.
  - q>MAX_COUNT: q<=MAX_COUNT, wrap<=0.
  - Otherwise q<=q-1, wrap<=0.
- HOLD mode: q unchanged, wrap<=0.
- Counter implementation:
  - Counter modes drive each bit through its JK toggle input.
  - UP: bit i toggles when all lower bits are 1.
  - DOWN: bit i toggles when all lower bits are 0.
  - The modulo override forces the next value via set/clear terms.
  - The result must equal the arithmetic rules above.
- tc:
  - 1 when (mode==UP and q>=MAX_COUNT) or (mode==DOWN and q==0).
  - 0 otherwise, including in JK and HOLD modes.
- Mode change mid-count takes effect on the next edge with no extra cycle.
- Reset mid-count aborts immediately. The first count after release starts from 0.

Optional Feature:
- Macro: JKC_SATURATE_EN.
- Defined:
  - UP stops at MAX_COUNT; q>MAX_COUNT is forced to MAX_COUNT.
  - DOWN stops at 0.
  - wrap is never asserted.
  - tc is unchanged.
- Undefined: modulo wrap behaviour as above.

Decomposition:
- Package jkc_pkg holds:
  - mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_HOLD=2'b11.
  - the JK action encoding.
- Sub-module jk_bit: one JK flop with asynchronous active-low rst, en, synchronous set/clear override, and q/qbar outputs. It is instantiated WIDTH times.
- The top level holds the toggle-term generation, modulo/saturate logic, tc and the wrap register.

Test Plan:
- Reset: drive rst=0 mid-cycle with q=4'b1011 -> q=0 and qbar=4'b1111 without waiting for a clk edge; wrap=0.
- JK mode, WIDTH=4, q=0: apply j=4'b0011,k=4'b0000, then j=4'b1111,k=4'b1111, then j=4'b0000,k=4'b0001 -> q sequence 0011, 1100, 1100 (bit0 already 0).
- UP mode, MAX_COUNT=9: run 12 enabled cycles from 0 -> q counts 0..9,0,1,2; tc=1 only at q=9; wrap=1 exactly one cycle after q=9.
- DOWN mode, MAX_COUNT=9: load din=2, then count 4 cycles -> q=1,0,9,8; wrap pulses once when q goes 0->9; tc=1 while q=0.
- Priority and enable:
  - en=0 with load=1 -> q holds.
  - en=1, load=1, mode=UP, din=7 -> q=7, no increment.
  - mode=HOLD for 3 cycles -> q unchanged.
- Build with JKC_SATURATE_EN, MAX_COUNT=9:
  - UP from 8 for 3 cycles -> 9,9,9, wrap never asserted.
  - DOWN from 1 -> 0,0.
  - Load 14 then UP -> 9.
